ebr_fifo_ctrl: RTL and testbench

EBR_FIFO_CTRL -- requirements
Module: ebr_fifo_ctrl

---
 rtl/ebr_fifo_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ebr_fifo_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ebr_fifo_ctrl.sv
// rtl/ebr_fifo_ctrl.sv - 256x16 EBR-backed FWFT FIFO controller with 2-entry output buffer (optional flush: EBR_FIFO_CTRL_FLUSH_EN)

// Behavioural stand-in for the 4 Kbit pseudo-dual-port EBR; 256x16 mode only, registered read.
module PDP4K #(
    parameter string DATA_WIDTH_W = "16",
    parameter string DATA_WIDTH_R = "16"
) (
    input  logic [15:0] DI,
    input  logic [10:0] ADW,
    input  logic [10:0] ADR,
    input  logic        CKW,
    input  logic        CKR,
    input  logic        CEW,
    input  logic        CER,
    input  logic        RE,
    input  logic        WE,
    input  logic [15:0] MASK_N,
    output logic [15:0] DO
);
    localparam bit unused_width_ok = (DATA_WIDTH_W == "16") && (DATA_WIDTH_R == "16");

    logic [15:0] mem [0:255];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{ADW[10:8], ADR[10:8]};

    // Write port: MASK_N bits that are 0 are written
    always_ff @(posedge CKW) begin
        if (CEW && WE) begin
            mem[ADW[7:0]] <= (mem[ADW[7:0]] & MASK_N) | (DI & ~MASK_N);
        end
    end

    // Read port: data appears on DO after the read clock edge
    always_ff @(posedge CKR) begin
        if (CER && RE) begin
            DO <= mem[ADR[7:0]];
        end
    end
endmodule

module ebr_fifo_ctrl #(
    parameter int AFULL_THRESH = 240
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef EBR_FIFO_CTRL_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [8:0]  level,
    output logic        afull
);
    logic [7:0]  wptr;
    logic [7:0]  rptr;
    logic [8:0]  mem_cnt;
    logic        inflight;
    logic [1:0]  obuf_cnt;
    logic [15:0] obuf1;
    logic        s_ready_q;
    logic [15:0] ebr_do;

    logic        flush_hit;
    logic        wr;
    logic        rd;
    logic        pop;
    logic [8:0]  mem_cnt_nxt;
    logic [1:0]  obuf_cnt_nxt;
    logic [8:0]  level_nxt;

`ifdef EBR_FIFO_CTRL_FLUSH_EN
    assign flush_hit = flush;
`else
    assign flush_hit = 1'b0;
`endif

    assign s_ready = s_ready_q && !flush_hit;
    assign wr      = s_valid && s_ready;
    assign m_valid = (obuf_cnt != 2'd0);
    assign pop     = m_valid && m_ready;

    // Issue a read only when buffer slots (after this cycle's pop) cover the in-flight word plus a new one
    always_comb begin
        rd = 1'b0;
        if ((mem_cnt != 9'd0) && !flush_hit &&
            (({1'b0, obuf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}))) begin
            rd = 1'b1;
        end
    end

    // Next-state occupancy; a write counts toward mem_cnt only after its edge
    always_comb begin
        mem_cnt_nxt  = mem_cnt + {8'd0, wr} - {8'd0, rd};
        obuf_cnt_nxt = obuf_cnt + {1'b0, inflight} - {1'b0, pop};
        level_nxt    = mem_cnt_nxt + {8'd0, rd} + {7'd0, obuf_cnt_nxt};
        if (flush_hit) begin
            mem_cnt_nxt  = 9'd0;
            obuf_cnt_nxt = 2'd0;
            level_nxt    = 9'd0;
        end
    end

    // Pointers, counters and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= 8'd0;
            rptr      <= 8'd0;
            mem_cnt   <= 9'd0;
            inflight  <= 1'b0;
            obuf_cnt  <= 2'd0;
            s_ready_q <= 1'b0;
            level     <= 9'd0;
            afull     <= 1'b0;
        end else begin
            wptr      <= flush_hit ? 8'd0 : wptr + {7'd0, wr};
            rptr      <= flush_hit ? 8'd0 : rptr + {7'd0, rd};
            mem_cnt   <= mem_cnt_nxt;
            inflight  <= rd;
            obuf_cnt  <= obuf_cnt_nxt;
            s_ready_q <= (mem_cnt_nxt < 9'd256);
            level     <= level_nxt;
            afull     <= ({23'd0, level_nxt} >= AFULL_THRESH);
        end
    end

    // Output buffer: head lives in m_data, second entry in obuf1; EBR DO captured the cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= 16'd0;
            obuf1  <= 16'd0;
        end else if (!flush_hit) begin
            if (pop) begin
                if (inflight && (obuf_cnt == 2'd1)) begin
                    m_data <= ebr_do;
                end else begin
                    m_data <= obuf1;
                end
                if (inflight && (obuf_cnt == 2'd2)) begin
                    obuf1 <= ebr_do;
                end
            end else if (inflight) begin
                if (obuf_cnt == 2'd0) begin
                    m_data <= ebr_do;
                end else begin
                    obuf1 <= ebr_do;
                end
            end
        end
    end

    PDP4K #(
        .DATA_WIDTH_W ("16"),
        .DATA_WIDTH_R ("16")
    ) u_ebr (
        .DI     (s_data),
        .ADW    ({3'b000, wptr}),
        .ADR    ({3'b000, rptr}),
        .CKW    (clk),
        .CKR    (clk),
        .CEW    (wr),
        .CER    (rd),
        .RE     (rd),
        .WE     (wr),
        .MASK_N (16'h0000),
        .DO     (ebr_do)
    );
endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// tb/tb_ebr_fifo_ctrl.sv - directed/table-driven self-checking bench for ebr_fifo_ctrl
module tb_ebr_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [8:0]  level;
    logic        afull;
`ifdef EBR_FIFO_CTRL_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ebr_fifo_ctrl #(.AFULL_THRESH(240)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef EBR_FIFO_CTRL_FLUSH_EN
        .flush   (flush),
`endif
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .afull   (afull)
    );

    typedef struct {
        logic        sv;
        logic [15:0] sd;
        logic        mr;
        logic        exp_sr;
        logic        exp_mv;
        logic [15:0] exp_md;
        logic [8:0]  exp_lvl;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int idx, accepted, afull_bad, first_afull_lvl, rx, bad, gaps, tx, cyc;
    logic [15:0] q [$];
    logic [15:0] exp_w;

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        m_ready = 1'b1;
`ifdef EBR_FIFO_CTRL_FLUSH_EN
        flush   = 1'b0;
`endif
        vecs[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA5A5, 9'd1};
        vecs[4]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};
        vecs[5]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd2};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 9'd2};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111, 9'd2};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2222, 9'd1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};

        // Reset held with s_valid asserted
        repeat (3) next_cycle();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_level", {23'd0, level}, 32'd0);
        chk("rst_afull", {31'd0, afull}, 32'd0);
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("rel_s_ready_before_edge", {31'd0, s_ready}, 32'd0);
        next_cycle();
        chk("rel_s_ready_after_edge", {31'd0, s_ready}, 32'd1);

        // Table: first-word latency, hold while stalled, back-to-back pops
        for (int i = 0; i <= 10; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].exp_sr});
            chk($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_mv});
            chk($sformatf("vec%0d_level", i), {23'd0, level}, {23'd0, vecs[i].exp_lvl});
            if (vecs[i].exp_mv) begin
                chk($sformatf("vec%0d_m_data", i), {16'd0, m_data}, {16'd0, vecs[i].exp_md});
            end
            next_cycle();
        end

        // Fill with the consumer stalled
        m_ready = 1'b0;
        idx = 0; accepted = 0; afull_bad = 0; first_afull_lvl = -1;
        for (int c = 0; c < 320; c++) begin
            s_valid = (idx < 300);
            s_data  = idx[15:0];
            @(negedge clk);
            if (afull !== (level >= 9'd240)) afull_bad++;
            if (afull && first_afull_lvl < 0) first_afull_lvl = int'(level);
            if (s_valid && s_ready) begin
                accepted++;
                idx++;
            end
            next_cycle();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("fill_accepted", accepted, 258);
        chk("fill_level", {23'd0, level}, 32'd258);
        chk("fill_s_ready", {31'd0, s_ready}, 32'd0);
        chk("fill_afull", {31'd0, afull}, 32'd1);
        chk("fill_afull_tracks_level", afull_bad, 0);
        chk("fill_afull_first_level", first_afull_lvl, 240);
        next_cycle();

        // Drain from full
        m_ready = 1'b1;
        rx = 0; bad = 0; gaps = 0;
        for (int c = 0; c < 400 && rx < 258; c++) begin
            @(negedge clk);
            if (m_valid) begin
                if (m_data !== rx[15:0]) bad++;
                rx++;
            end else if (rx > 0) begin
                gaps++;
            end
            next_cycle();
        end
        @(negedge clk);
        chk("drain_count", rx, 258);
        chk("drain_order", bad, 0);
        chk("drain_gaps", gaps, 0);
        chk("drain_level", {23'd0, level}, 32'd0);
        chk("drain_m_valid", {31'd0, m_valid}, 32'd0);
        next_cycle();

        // Random streaming across pointer wrap
        tx = 0; rx = 0; bad = 0; cyc = 0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        while (rx < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                tx++;
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    bad++;
                end else begin
                    exp_w = q.pop_front();
                    if (m_data !== exp_w) bad++;
                end
                rx++;
            end
            next_cycle();
            s_valid = (tx < 1000) && ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("stream_count", rx, 1000);
        chk("stream_data", bad, 0);
        chk("stream_level", {23'd0, level}, 32'd0);
        next_cycle();

`ifdef EBR_FIFO_CTRL_FLUSH_EN
        // Flush while a read is in flight
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h0100 + 16'(i);
            next_cycle();
        end
        s_valid = 1'b0;
        repeat (4) next_cycle();
        m_ready = 1'b1;
        next_cycle();
        m_ready = 1'b0;
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        @(negedge clk);
        chk("flush_s_ready_low", {31'd0, s_ready}, 32'd0);
        next_cycle();
        flush   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("flush_level", {23'd0, level}, 32'd0);
        chk("flush_m_valid", {31'd0, m_valid}, 32'd0);
        next_cycle();
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        next_cycle();
        s_valid = 1'b0;
        rx = 0;
        for (int c = 0; c < 10 && rx == 0; c++) begin
            @(negedge clk);
            if (m_valid) begin
                chk("flush_first_word", {16'd0, m_data}, 32'h0000BEEF);
                rx = 1;
            end
            next_cycle();
        end
        chk("flush_first_word_seen", rx, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
